// File: rtl/sync_proto_pkg.sv
// Shared definitions for the Xike sync pulse-train protocol (encoder and decoder).
package sync_proto_pkg;

    // Seconds field width and default timing, in 100 MHz clock cycles.
    localparam int SYNC_SEC_W      = 12;
    localparam int SYNC_CNT_W      = 20;
    localparam int SYNC_START_MIN  = 700000;   // 7 ms
    localparam int SYNC_START_MAX  = 900000;   // 9 ms
    localparam int SYNC_BIT_MIN    = 50000;    // 0.5 ms
    localparam int SYNC_BIT_THRESH = 200000;   // 2 ms: '0' is 1 ms, '1' is 3 ms
    localparam int SYNC_BIT_MAX    = 400000;   // 4 ms
    localparam int SYNC_TIMEOUT    = 1000000;  // 10 ms low gap

    typedef enum logic [2:0] {
        IDLE,
        START_HI,
        WAIT_BIT,
        BIT_HI,
        DONE
    } sync_state_e;

endpackage

// File: rtl/bcs_sync_decoder_if.sv
// Pin side and decoded-result side of the sync decoder.
interface bcs_sync_decoder_if
    import sync_proto_pkg::*;
#(
    parameter int SEC_W = SYNC_SEC_W
);
    logic             sync_in;      // raw pin, asynchronous
    logic [31:0]      frame_No;     // local frame counter
    logic [SEC_W-1:0] sec_out;
    logic             sec_vld;
    logic [31:0]      frame_No_at;
    logic             frame_err;
    logic             seq_err;
    logic [15:0]      ok_cnt;
    logic [15:0]      err_cnt;

    // Source of the pulse train and frame counter, consumer of results.
    modport master (
        output sync_in, frame_No,
        input  sec_out, sec_vld, frame_No_at, frame_err, seq_err, ok_cnt, err_cnt
    );

    // The decoder itself.
    modport slave (
        input  sync_in, frame_No,
        output sec_out, sec_vld, frame_No_at, frame_err, seq_err, ok_cnt, err_cnt
    );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for the sync pin plus a delay flop for edge detection.
// A pin edge shows up as a one-cycle rise/fall pulse in the third cycle.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic rise_o,
    output logic fall_o
);
    // [0],[1] synchronizer, [2] previous synchronized level
    logic [2:0] sync_q;

    // Shift the pin through the synchronizer and delay stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din_i};
        end
    end

    assign rise_o =  sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/bcs_sync_decoder.sv
// Sync pulse-train receiver: measures pulse/gap widths, decodes the seconds
// field MSB first, checks frame-to-frame sequence and keeps good/error counts.
module bcs_sync_decoder
    import sync_proto_pkg::*;
#(
    parameter int SEC_W      = SYNC_SEC_W,
    parameter int CNT_W      = SYNC_CNT_W,
    parameter int START_MIN  = SYNC_START_MIN,
    parameter int START_MAX  = SYNC_START_MAX,
    parameter int BIT_MIN    = SYNC_BIT_MIN,
    parameter int BIT_THRESH = SYNC_BIT_THRESH,
    parameter int BIT_MAX    = SYNC_BIT_MAX,
    parameter int TIMEOUT    = SYNC_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    bcs_sync_decoder_if.slave bus
);
    localparam int IDX_W = $clog2(SEC_W + 1);

    localparam logic [CNT_W-1:0] START_MIN_C  = CNT_W'(START_MIN);
    localparam logic [CNT_W-1:0] START_MAX_C  = CNT_W'(START_MAX);
    localparam logic [CNT_W-1:0] BIT_MIN_C    = CNT_W'(BIT_MIN);
    localparam logic [CNT_W-1:0] BIT_THRESH_C = CNT_W'(BIT_THRESH);
    localparam logic [CNT_W-1:0] BIT_MAX_C    = CNT_W'(BIT_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(SEC_W - 1);

    logic sync_rise;
    logic sync_fall;

    sync_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [SEC_W-1:0] shift_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [31:0]      start_fn_q;
    logic             have_prev_q;
    logic [SEC_W-1:0] last_q;
    logic [SEC_W-1:0] last_inc;

    logic [SEC_W-1:0] sec_out_q;
    logic             sec_vld_q;
    logic [31:0]      frame_no_at_q;
    logic             frame_err_q;
    logic             seq_err_q;
    logic [15:0]      ok_cnt_q;
    logic [15:0]      err_cnt_q;

    // FSM control strobes
    logic cap_fn;
    logic idx_clr;
    logic shift_en;
    logic done;
    logic err;

    sync_edge_det u_edge (
        .clk    (clk),
        .rst    (rst),
        .din_i  (bus.sync_in),
        .rise_o (sync_rise),
        .fall_o (sync_fall)
    );

    // Width of the current level; restarts on every edge, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (sync_rise || sync_fall) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Over-width and timeout checks take priority over a
    // coincident edge, so a fall at max+1 or a rise at TIMEOUT is an error.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sync_rise) state_d = START_HI;
            end
            START_HI: begin
                if (cnt_q > START_MAX_C) begin
                    state_d = IDLE;
                end else if (sync_fall) begin
                    state_d = (cnt_q >= START_MIN_C) ? WAIT_BIT : IDLE;
                end
            end
            WAIT_BIT: begin
                if (cnt_q == TIMEOUT_C) begin
                    state_d = IDLE;
                end else if (sync_rise) begin
                    state_d = BIT_HI;
                end
            end
            BIT_HI: begin
                if (cnt_q > BIT_MAX_C) begin
                    state_d = IDLE;
                end else if (sync_fall) begin
                    if (cnt_q < BIT_MIN_C)         state_d = IDLE;
                    else if (bit_idx_q == LAST_IDX) state_d = DONE;
                    else                            state_d = WAIT_BIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control strobes for the datapath. A short start pulse is dropped
    // silently as a glitch; only over-long pulses and timeouts raise err.
    always_comb begin
        cap_fn   = 1'b0;
        idx_clr  = 1'b0;
        shift_en = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            IDLE: cap_fn = sync_rise;
            START_HI: begin
                err     = cnt_q > START_MAX_C;
                idx_clr = !err && sync_fall && (cnt_q >= START_MIN_C);
            end
            WAIT_BIT: err = cnt_q == TIMEOUT_C;
            BIT_HI: begin
                err      = (cnt_q > BIT_MAX_C) || (sync_fall && (cnt_q < BIT_MIN_C));
                shift_en = !err && sync_fall;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign last_inc = last_q + SEC_W'(1);

    // Frame datapath: capture frame_No, shift in bits, publish on DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q       <= '0;
            bit_idx_q     <= '0;
            start_fn_q    <= '0;
            have_prev_q   <= 1'b0;
            last_q        <= '0;
            sec_out_q     <= '0;
            sec_vld_q     <= 1'b0;
            frame_no_at_q <= '0;
            frame_err_q   <= 1'b0;
            seq_err_q     <= 1'b0;
            ok_cnt_q      <= '0;
            err_cnt_q     <= '0;
        end else begin
            if (cap_fn) start_fn_q <= bus.frame_No;
            if (idx_clr) begin
                bit_idx_q <= '0;
                shift_q   <= '0;
            end
            if (shift_en) begin
                shift_q   <= {shift_q[SEC_W-2:0], (cnt_q >= BIT_THRESH_C)};
                bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
            sec_vld_q   <= done;
            frame_err_q <= err;
            seq_err_q   <= done && have_prev_q && (shift_q != last_inc);
            if (done) begin
                sec_out_q     <= shift_q;
                frame_no_at_q <= start_fn_q;
                ok_cnt_q      <= ok_cnt_q + 16'd1;
                have_prev_q   <= 1'b1;
                last_q        <= shift_q;
            end
            if (err) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign bus.sec_out     = sec_out_q;
    assign bus.sec_vld     = sec_vld_q;
    assign bus.frame_No_at = frame_no_at_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.ok_cnt      = ok_cnt_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_bcs_sync_decoder.sv
// Scoreboard bench for bcs_sync_decoder with timing scaled down 1000x.
module tb_bcs_sync_decoder;

    localparam int T_SEC_W   = 12;
    localparam int T_TIMEOUT = 1000;
    localparam int START_W   = 800;
    localparam int GAP       = 100;
    localparam int ONE_W     = 300;
    localparam int ZERO_W    = 100;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    bcs_sync_decoder_if #(.SEC_W(T_SEC_W)) bus ();

    bcs_sync_decoder #(
        .SEC_W      (T_SEC_W),
        .CNT_W      (20),
        .START_MIN  (700),
        .START_MAX  (900),
        .BIT_MIN    (50),
        .BIT_THRESH (200),
        .BIT_MAX    (400),
        .TIMEOUT    (T_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [11:0] sec;
        logic [31:0] fn;
        logic        seq;
        logic [15:0] ok;
        int          cyc;
    } vld_exp_t;

    typedef struct {
        logic [15:0] err;
        int          cyc;
    } err_exp_t;

    vld_exp_t vq[$];
    err_exp_t eq[$];
    vld_exp_t ve;
    err_exp_t ee;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever the DUT strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sec_vld) begin
                if (vq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_sec_vld: got sec 0x%0h expected no strobe", bus.sec_out);
                end else begin
                    ve = vq.pop_front();
                    check("sec_out", 32'(bus.sec_out), 32'(ve.sec));
                    check("frame_No_at", bus.frame_No_at, ve.fn);
                    check("seq_err", 32'(bus.seq_err), 32'(ve.seq));
                    check("ok_cnt", 32'(bus.ok_cnt), 32'(ve.ok));
                    check("vld_cycle", cyc, ve.cyc);
                end
            end else if (bus.seq_err) begin
                n_tests++;
                n_fail++;
                $display("FAIL seq_err_alone: got seq_err=1 expected 0 without sec_vld");
            end
            if (bus.frame_err) begin
                if (eq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame_err: got err_cnt %0d expected no strobe", bus.err_cnt);
                end else begin
                    ee = eq.pop_front();
                    check("err_cnt", 32'(bus.err_cnt), 32'(ee.err));
                    check("err_cycle", cyc, ee.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, output int fall_cyc);
        bus.sync_in = 1'b1;
        tick(hi);
        bus.sync_in = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(5);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sec_out"},     32'(bus.sec_out), 0);
        check({tag, "_sec_vld"},     32'(bus.sec_vld), 0);
        check({tag, "_frame_No_at"}, bus.frame_No_at, 0);
        check({tag, "_frame_err"},   32'(bus.frame_err), 0);
        check({tag, "_seq_err"},     32'(bus.seq_err), 0);
        check({tag, "_ok_cnt"},      32'(bus.ok_cnt), 0);
        check({tag, "_err_cnt"},     32'(bus.err_cnt), 0);
    endtask

    task automatic send_start(input logic [31:0] fn);
        int fc;
        bus.frame_No = fn;
        pulse(START_W, fc);
        tick(GAP);
    endtask

    // Full frame; expectation queued right after the final pin fall.
    task automatic send_frame(input logic [11:0] v, input logic [31:0] fn,
                              input logic seq, input logic [15:0] ok);
        int fc;
        send_start(fn);
        for (int i = 11; i >= 0; i--) begin
            pulse(v[i] ? ONE_W : ZERO_W, fc);
            if (i == 0) vq.push_back('{sec: v, fn: fn, seq: seq, ok: ok, cyc: fc + 4});
            tick(GAP);
        end
        tick(50);
    endtask

    initial begin
        int fc;
        logic [11:0] part;
        rst = 1'b1;
        bus.sync_in = 1'b0;
        bus.frame_No = '0;
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(5);

        // Basic decode and frame_No capture.
        send_frame(12'h005, 32'd1234, 1'b0, 16'd1);

        // Seconds wrap 4095 -> 0 stays in sequence.
        do_reset();
        send_frame(12'hFFE, 32'd2000, 1'b0, 16'd1);
        send_frame(12'hFFF, 32'd2001, 1'b0, 16'd2);
        send_frame(12'h000, 32'd2002, 1'b0, 16'd3);

        // Skipped second.
        do_reset();
        send_frame(12'h00A, 32'd3000, 1'b0, 16'd1);
        send_frame(12'h00C, 32'd3001, 1'b1, 16'd2);

        // 2 ms start pulse is ignored without any strobe.
        pulse(200, fc);
        tick(GAP * 10);
        check("short_start_ok_cnt", 32'(bus.ok_cnt), 2);
        check("short_start_err_cnt", 32'(bus.err_cnt), 0);
        check("short_start_sec_out", 32'(bus.sec_out), 32'h00C);

        // Valid start, then a 0.2 ms bit.
        send_start(32'd5);
        pulse(20, fc);
        eq.push_back('{err: 16'd1, cyc: fc + 3});
        tick(200);

        // Five bits then a long low gap.
        send_start(32'd6);
        for (int i = 0; i < 5; i++) begin
            pulse((i % 2 == 0) ? ONE_W : ZERO_W, fc);
            if (i == 4) eq.push_back('{err: 16'd2, cyc: fc + T_TIMEOUT + 4});
            else tick(GAP);
        end
        tick(1500);
        send_frame(12'h00D, 32'd4000, 1'b0, 16'd3);

        // Reset while bit 7 is high.
        part = 12'h456;
        send_start(32'd6000);
        for (int i = 11; i >= 5; i--) begin
            pulse(part[i] ? ONE_W : ZERO_W, fc);
            tick(GAP);
        end
        bus.sync_in = 1'b1;
        tick(150);
        rst = 1'b1;
        tick(1);
        check_zero("mid_rst");
        tick(1);
        rst = 1'b0;
        tick(150);
        bus.sync_in = 1'b0;
        tick(300);
        send_frame(12'h123, 32'd77, 1'b0, 16'd1);

        tick(20);
        check("pending_sec_vld", vq.size(), 0);
        check("pending_frame_err", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
